enum_stepper: RTL and testbench

// - Generates the value stream for a sparse enumeration, upstream of the enum-method checkers.
// - Holds a current member of a parameterised sparse encoding table.
// - Steps it forward/backward with wrap, as SV next()/prev() do, or loads an arbitrary raw value.
// - Flags values that are not table members and reports each member's ordinal position.

---
 rtl/enum_stepper_if.sv | 25 ++
 rtl/enum_stepper.sv | 151 +++++++++++++++
 tb/tb_enum_stepper.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/enum_stepper_if.sv
// Command/status bundle for enum_stepper: valid/ready command
// channel plus the registered enumeration outputs.
interface enum_stepper_if #(
  parameter int WIDTH = 32,
  parameter int IDXW  = 1
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] value;
  logic [IDXW-1:0]  index;
  logic             known;
  logic             wrapped;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, value, index, known, wrapped
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, value, index, known, wrapped
  );
endinterface

// File: rtl/enum_stepper.sv
// Sparse-enum stepper: next/prev with wrap, LOAD with serial table search.
// Optional wrap counter output enabled by ENUM_STEPPER_WRAPCNT_EN.
module enum_stepper #(
  parameter int WIDTH = 32,
  parameter int NUM   = 2,
  parameter logic [NUM*WIDTH-1:0] VALUES = {32'h0000f00d, 32'h00000001},
  parameter int IDXW  = $clog2(NUM)
) (
  input  logic clk,
  input  logic reset,
`ifdef ENUM_STEPPER_WRAPCNT_EN
  output logic [7:0] wrap_count,
`endif
  enum_stepper_if.slave bus
);

  typedef enum logic {
    IDLE,
    SEARCH
  } state_e;

  localparam logic [IDXW-1:0] LAST = IDXW'(NUM - 1);

  logic [WIDTH-1:0] tbl [NUM];

  for (genvar g = 0; g < NUM; g++) begin : g_tbl
    assign tbl[g] = VALUES[g*WIDTH +: WIDTH];
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             known_q, known_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDXW-1:0]  ptr_q, ptr_d;
`ifdef ENUM_STEPPER_WRAPCNT_EN
  logic [7:0]       cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    idx_d   = idx_q;
    known_d = known_q;
    wrap_d  = 1'b0;
    data_d  = data_q;
    ptr_d   = ptr_q;
`ifdef ENUM_STEPPER_WRAPCNT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          unique case (bus.cmd_op)
            2'b00: ;
            2'b01: begin
              // Stepping from a non-member restarts the walk, no wrap
              if (!known_q) begin
                idx_d = '0;
              end else if (idx_q == LAST) begin
                idx_d  = '0;
                wrap_d = 1'b1;
              end else begin
                idx_d = idx_q + IDXW'(1);
              end
              val_d   = tbl[idx_d];
              known_d = 1'b1;
            end
            2'b10: begin
              if (!known_q) begin
                idx_d = LAST;
              end else if (idx_q == '0) begin
                idx_d  = LAST;
                wrap_d = 1'b1;
              end else begin
                idx_d = idx_q - IDXW'(1);
              end
              val_d   = tbl[idx_d];
              known_d = 1'b1;
            end
            2'b11: begin
              data_d  = bus.cmd_data;
              ptr_d   = '0;
              state_d = SEARCH;
            end
          endcase
        end
      end
      SEARCH: begin
        if (tbl[ptr_q] == data_q) begin
          val_d   = data_q;
          idx_d   = ptr_q;
          known_d = 1'b1;
          state_d = IDLE;
        end else if (ptr_q == LAST) begin
          val_d   = data_q;
          idx_d   = '0;
          known_d = 1'b0;
          state_d = IDLE;
`ifdef ENUM_STEPPER_WRAPCNT_EN
          cnt_d   = '0;
`endif
        end else begin
          ptr_d = ptr_q + IDXW'(1);
        end
      end
    endcase
`ifdef ENUM_STEPPER_WRAPCNT_EN
    if (wrap_d && cnt_q != 8'hff) begin
      cnt_d = cnt_q + 8'd1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      val_q   <= tbl[0];
      idx_q   <= '0;
      known_q <= 1'b1;
      wrap_q  <= 1'b0;
      data_q  <= '0;
      ptr_q   <= '0;
`ifdef ENUM_STEPPER_WRAPCNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      idx_q   <= idx_d;
      known_q <= known_d;
      wrap_q  <= wrap_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
`ifdef ENUM_STEPPER_WRAPCNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.value     = val_q;
  assign bus.index     = idx_q;
  assign bus.known     = known_q;
  assign bus.wrapped   = wrap_q;
`ifdef ENUM_STEPPER_WRAPCNT_EN
  assign wrap_count    = cnt_q;
`endif

endmodule

// File: tb/tb_enum_stepper.sv
// Bench for enum_stepper: directed literal checks plus random
// commands against a cycle-level behavioural model.
module tb_enum_stepper;

  localparam int WIDTH = 32;
  localparam int NUM   = 2;
  localparam int IDXW  = 1;

  logic clk = 1'b0;
  logic reset;

  enum_stepper_if #(.WIDTH(WIDTH), .IDXW(IDXW)) bus ();

`ifdef ENUM_STEPPER_WRAPCNT_EN
  logic [7:0] wrap_count;
`endif

  enum_stepper dut (
    .clk        (clk),
    .reset      (reset),
`ifdef ENUM_STEPPER_WRAPCNT_EN
    .wrap_count (wrap_count),
`endif
    .bus        (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] tv [NUM];

  int checks = 0;
  int errors = 0;

  // model state
  logic [31:0] m_val;
  int          m_idx;
  bit          m_known;
  bit          m_wrap;
  int          m_busy;
  logic [31:0] p_val;
  int          p_idx;
  bit          p_known;
  int          m_wc;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_val   = tv[0];
    m_idx   = 0;
    m_known = 1;
    m_wrap  = 0;
    m_busy  = 0;
    m_wc    = 0;
  endtask

  // Model advance for one rising edge, given the inputs seen at it
  task automatic model_edge(input bit r, input bit v,
                            input logic [1:0] op, input logic [31:0] d);
    int hit;
    if (r) begin
      model_reset();
      return;
    end
    m_wrap = 0;
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_val   = p_val;
        m_idx   = p_idx;
        m_known = p_known;
        if (!p_known) m_wc = 0;
      end
    end else if (v) begin
      case (op)
        2'b01: begin
          if (!m_known) m_idx = 0;
          else begin
            m_wrap = (m_idx + 1 == NUM);
            m_idx  = (m_idx + 1) % NUM;
          end
          m_val = tv[m_idx]; m_known = 1;
        end
        2'b10: begin
          if (!m_known) m_idx = NUM - 1;
          else begin
            m_wrap = (m_idx == 0);
            m_idx  = (m_idx + NUM - 1) % NUM;
          end
          m_val = tv[m_idx]; m_known = 1;
        end
        2'b11: begin
          hit = -1;
          for (int i = NUM - 1; i >= 0; i--)
            if (tv[i] == d) hit = i;
          p_val = d;
          if (hit >= 0) begin
            m_busy = hit + 1; p_idx = hit; p_known = 1;
          end else begin
            m_busy = NUM; p_idx = 0; p_known = 0;
          end
        end
        default: ;
      endcase
    end
    if (m_wrap && m_wc < 255) m_wc++;
  endtask

  task automatic compare();
    chk("value", bus.value, m_val);
    chk("index", bus.index, m_idx);
    chk("known", bus.known, m_known);
    chk("wrapped", bus.wrapped, m_wrap);
    chk("cmd_ready", bus.cmd_ready, m_busy == 0);
`ifdef ENUM_STEPPER_WRAPCNT_EN
    chk("wrap_count", wrap_count, m_wc);
`endif
  endtask

  // Drive at negedge, clock, update model, compare at the next negedge
  task automatic cycle(input bit v, input logic [1:0] op,
                       input logic [31:0] d, input bit r);
    reset         = r;
    bus.cmd_valid = v;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    @(posedge clk);
    model_edge(r, v, op, d);
    @(negedge clk);
    compare();
  endtask

  logic [31:0] rd;
  logic [1:0]  rop;

  initial begin
    tv[0] = 32'h00000001;
    tv[1] = 32'h0000f00d;
    model_reset();
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'b00;
    bus.cmd_data = '0;
    @(negedge clk);

    cycle(0, 2'b00, 0, 1);
    cycle(0, 2'b00, 0, 1);
    chk("rst_value", bus.value, 32'h1);
    chk("rst_index", bus.index, 0);
    chk("rst_known", bus.known, 1);
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_wrapped", bus.wrapped, 0);

    cycle(1, 2'b01, 0, 0);
    chk("next1_value", bus.value, 32'hf00d);
    chk("next1_index", bus.index, 1);
    chk("next1_wrapped", bus.wrapped, 0);
    cycle(1, 2'b01, 0, 0);
    chk("next2_value", bus.value, 32'h1);
    chk("next2_wrapped", bus.wrapped, 1);
    cycle(0, 2'b00, 0, 0);
    chk("wrap_pulse_end", bus.wrapped, 0);

    cycle(1, 2'b10, 0, 0);
    chk("prev1_value", bus.value, 32'hf00d);
    chk("prev1_wrapped", bus.wrapped, 1);
    cycle(1, 2'b10, 0, 0);
    chk("prev2_value", bus.value, 32'h1);
    chk("prev2_wrapped", bus.wrapped, 0);

    // LOAD f00d with valid held during the search
    cycle(1, 2'b11, 32'hf00d, 0);
    chk("ld_busy1", bus.cmd_ready, 0);
    cycle(1, 2'b01, 0, 0);
    chk("ld_busy2", bus.cmd_ready, 0);
    chk("ld_hold_value", bus.value, 32'h1);
    cycle(1, 2'b01, 0, 0);
    chk("ld_value", bus.value, 32'hf00d);
    chk("ld_index", bus.index, 1);
    chk("ld_known", bus.known, 1);
    chk("ld_ready", bus.cmd_ready, 1);

    cycle(1, 2'b11, 32'h11, 0);
    cycle(0, 2'b00, 0, 0);
    cycle(0, 2'b00, 0, 0);
    chk("ldu_value", bus.value, 32'h11);
    chk("ldu_index", bus.index, 0);
    chk("ldu_known", bus.known, 0);
    cycle(1, 2'b01, 0, 0);
    chk("nextu_value", bus.value, 32'h1);
    chk("nextu_known", bus.known, 1);
    chk("nextu_wrapped", bus.wrapped, 0);

    cycle(1, 2'b11, 32'h22, 0);
    cycle(0, 2'b00, 0, 0);
    cycle(0, 2'b00, 0, 0);
    cycle(1, 2'b10, 0, 0);
    chk("prevu_value", bus.value, 32'hf00d);
    chk("prevu_index", bus.index, 1);
    chk("prevu_wrapped", bus.wrapped, 0);

    cycle(1, 2'b11, 32'hf00d, 0);
    cycle(0, 2'b00, 0, 1);
    chk("midrst_value", bus.value, 32'h1);
    chk("midrst_ready", bus.cmd_ready, 1);
    cycle(0, 2'b00, 0, 0);
    cycle(0, 2'b00, 0, 0);
    chk("midrst_nocommit", bus.value, 32'h1);
    chk("midrst_index", bus.index, 0);

    for (int n = 0; n < 4000; n++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: rd = tv[0];
        1: rd = tv[1];
        2: rd = $urandom;
        default: rd = 32'($urandom_range(0, 3));
      endcase
      cycle($urandom_range(0, 3) != 0, rop, rd, $urandom_range(0, 59) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
